// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode->execute interlock: FSM states, forwarding selects, dest-pipe entry.
// Pure definitions, no latency or flow control of its own.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    JALR_WAIT = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam int LD_CNT_W = 3;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
  } dest_t;

  // Younger (EX) producer wins over MEM; x0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input dest_t ex, input dest_t mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (ex.vld && ex.wr && (ex.rd == rs))
        sel = FWD_EX;
      else if (mem.vld && mem.wr && (mem.rd == rs))
        sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Outstanding-load scoreboard: pending bit per register plus in-flight count; set wins over clear.
// Updates on the next clock edge; pend_byp exposes this cycle's response clear combinationally.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_LD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic        resp_valid,
  input  logic [4:0]  resp_rd,
  output logic [31:0] pend,
  output logic [31:0] pend_byp,
  output logic        full
);

  logic [LD_CNT_W-1:0] ld_cnt;
  logic                clr;
  logic [31:0]         set_mask;
  logic [31:0]         clr_mask;

  // A response with nothing in flight is spurious and must not underflow the count.
  assign clr      = resp_valid && (ld_cnt != '0);
  assign set_mask = (ld_issue && (ld_rd != 5'd0)) ? (32'd1 << ld_rd) : 32'd0;
  assign clr_mask = clr ? (32'd1 << resp_rd) : 32'd0;
  assign pend_byp = pend & ~clr_mask;
  assign full     = (ld_cnt == LD_CNT_W'(MAX_LD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= '0;
      ld_cnt <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
      case ({ld_issue, clr})
        2'b10:   ld_cnt <= ld_cnt + 1'b1;
        2'b01:   ld_cnt <= ld_cnt - 1'b1;
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode->execute interlock: load-use stalls, memory-accept hold, jalr redirect wait, operand forwarding.
// Stall/issue/forward are combinational this cycle; memory backpressure holds decode in MEM_WAIT.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int         MAX_LD   = 2,
  parameter logic [3:0] JALR_TMO = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rd1,
  input  logic        id_rd2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr,
  input  logic        id_load,
  input  logic        id_store,
  input  logic        id_jalr,
  input  logic        jalr_done,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [4:0]  mem_resp_rd,
  output logic        stall,
  output logic        flush_ex,
  output logic        issue,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [31:0] ld_pending,
  output logic        err_tmo
);

  state_t      state, state_nxt;
  logic [3:0]  tmo_cnt;
  logic        err_q;
  dest_t       ex_q, mem_q;
  logic [31:0] pend_byp;
  logic        ld_full;
  logic        raw_haz;
  logic        block;
  logic        mem_op;

  hazard_scoreboard #(.MAX_LD(MAX_LD)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .ld_issue   (issue & id_load),
    .ld_rd      (id_rd),
    .resp_valid (mem_resp_valid),
    .resp_rd    (mem_resp_rd),
    .pend       (ld_pending),
    .pend_byp   (pend_byp),
    .full       (ld_full)
  );

  // Uses the bypassed view so a load returning this cycle releases its consumer immediately.
  assign raw_haz = id_valid &&
                   ((id_rd1 && (id_rs1 != 5'd0) && pend_byp[id_rs1]) ||
                    (id_rd2 && (id_rs2 != 5'd0) && pend_byp[id_rs2]));
  assign block   = raw_haz || (id_valid && id_load && ld_full);
  assign mem_op  = id_load || id_store;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    flush_ex  = 1'b0;
    issue     = 1'b0;
    case (state)
      RUN: begin
        if (block) begin
          stall    = 1'b1;
          flush_ex = 1'b1;
        end else if (id_valid && mem_op && !mem_req_ready) begin
          stall     = 1'b1;
          flush_ex  = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          issue = id_valid;
          if (id_valid && id_jalr)
            state_nxt = JALR_WAIT;
        end
      end
      JALR_WAIT: begin
        stall    = 1'b1;
        flush_ex = 1'b1;
        if (jalr_done)
          state_nxt = RUN;
      end
      MEM_WAIT: begin
        if (mem_req_ready) begin
          issue     = id_valid;
          state_nxt = RUN;
        end else begin
          stall    = 1'b1;
          flush_ex = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // Held-in-reset must look idle even if decode presents a valid instruction.
    if (!rst) begin
      stall     = 1'b0;
      flush_ex  = 1'b0;
      issue     = 1'b0;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (state == JALR_WAIT) begin
      if (tmo_cnt != 4'hF)
        tmo_cnt <= tmo_cnt + 4'd1;
      if (tmo_cnt == JALR_TMO)
        err_q <= 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Loads are excluded: their data is not ready from EX/MEM and the scoreboard covers them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= {issue, id_rd, id_wr & ~id_load};
      mem_q <= ex_q;
    end
  end

  assign fwd1_sel = fwd_pick(id_rs1, ex_q, mem_q);
  assign fwd2_sel = fwd_pick(id_rs2, ex_q, mem_q);
  assign err_tmo  = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed spec scenarios followed by randomized traffic, all checked against a behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_LD = 2;
  localparam int TMO    = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rd1, id_rd2, id_wr, id_load, id_store, id_jalr;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        jalr_done, mem_req_ready, mem_resp_valid;
  logic [4:0]  mem_resp_rd;
  logic        stall, flush_ex, issue, err_tmo;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] ld_pending;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_LD(MAX_LD), .JALR_TMO(4'd15)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .id_store(id_store), .id_jalr(id_jalr), .jalr_done(jalr_done),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_rd(mem_resp_rd),
    .stall(stall), .flush_ex(flush_ex), .issue(issue), .fwd1_sel(fwd1_sel),
    .fwd2_sel(fwd2_sel), .ld_pending(ld_pending), .err_tmo(err_tmo)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 running, 1 waiting for jalr target, 2 waiting for memory accept.
  typedef struct { bit v; int rd; bit w; } ent_t;
  int          mode, next_mode, m_out, m_wait;
  bit [31:0]   m_pend;
  bit          m_err;
  ent_t        hist[$];
  bit          e_stall, e_flush, e_issue;
  int          e_f1, e_f2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fwd_src(input logic [4:0] rs);
    if (rs == 5'd0) return 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].w && hist[i].rd == int'(rs)) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    mode = 0; m_out = 0; m_wait = 0; m_pend = '0; m_err = 0;
    hist.delete();
  endtask

  task automatic model_eval();
    bit [31:0] visible;
    bit        blocked;
    visible = m_pend;
    if (mem_resp_valid && m_out > 0) visible[mem_resp_rd] = 1'b0;
    blocked = id_valid && ((id_rd1 && id_rs1 != 0 && visible[id_rs1]) ||
                           (id_rd2 && id_rs2 != 0 && visible[id_rs2]));
    if (id_valid && id_load && m_out == MAX_LD) blocked = 1;
    e_stall = 0; e_flush = 0; e_issue = 0; next_mode = mode;
    if (mode == 0) begin
      if (blocked) begin
        e_stall = 1; e_flush = 1;
      end else if (id_valid && (id_load || id_store) && !mem_req_ready) begin
        e_stall = 1; e_flush = 1; next_mode = 2;
      end else begin
        e_issue = id_valid;
        if (id_valid && id_jalr) next_mode = 1;
      end
    end else if (mode == 1) begin
      e_stall = 1; e_flush = 1;
      if (jalr_done) next_mode = 0;
    end else begin
      if (mem_req_ready) begin
        e_issue = id_valid; next_mode = 0;
      end else begin
        e_stall = 1; e_flush = 1;
      end
    end
    e_f1 = fwd_src(id_rs1);
    e_f2 = fwd_src(id_rs2);
  endtask

  task automatic model_commit();
    ent_t e;
    if (mode == 1) begin
      m_wait++;
      if (m_wait >= TMO + 1) m_err = 1;
    end else begin
      m_wait = 0;
    end
    if (mem_resp_valid && m_out > 0) begin
      m_out--;
      m_pend[mem_resp_rd] = 1'b0;
    end
    if (e_issue && id_load) begin
      m_out++;
      if (id_rd != 0) m_pend[id_rd] = 1'b1;
    end
    e.v = e_issue; e.rd = int'(id_rd); e.w = id_wr && !id_load;
    hist.push_front(e);
    if (hist.size() > 2) void'(hist.pop_back());
    mode = next_mode;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("stall", stall, e_stall);
    chk("flush_ex", flush_ex, e_flush);
    chk("issue", issue, e_issue);
    chk("fwd1_sel", fwd1_sel, e_f1);
    chk("fwd2_sel", fwd2_sel, e_f2);
    chk("ld_pending", ld_pending, m_pend);
    chk("err_tmo", err_tmo, m_err);
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, ld, st, jr, wr, r1, r2, input logic [4:0] rd, rs1, rs2);
    id_valid = v; id_load = ld; id_store = st; id_jalr = jr; id_wr = wr;
    id_rd1 = r1; id_rd2 = r2; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask
  task automatic nop();                      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic alu(input logic [4:0] d, a, b); set_id(1, 0, 0, 0, 1, 1, 1, d, a, b); endtask
  task automatic lw(input logic [4:0] d, a);     set_id(1, 1, 0, 0, 1, 1, 0, d, a, 0); endtask
  task automatic sw(input logic [4:0] a, b);     set_id(1, 0, 1, 0, 0, 1, 1, 0, a, b); endtask
  task automatic jalr(input logic [4:0] d, a);   set_id(1, 0, 0, 1, 1, 1, 0, d, a, 0); endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_flush"}, flush_ex, 0);
    chk({tag, "_issue"}, issue, 0);
    chk({tag, "_fwd"}, {fwd1_sel, fwd2_sel}, 0);
    chk({tag, "_pend"}, ld_pending, 0);
    chk({tag, "_err"}, err_tmo, 0);
  endtask

  initial begin
    int  cnt;
    bit  held;
    int  kind;

    rst = 1'b0; nop();
    jalr_done = 0; mem_req_ready = 1; mem_resp_valid = 0; mem_resp_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Forwarding: EX, MEM, and x0
    alu(3, 1, 2); cycle();
    alu(4, 3, 3); #1;
    chk("fwd_ex_rs1", fwd1_sel, 1); chk("fwd_ex_rs2", fwd2_sel, 1);
    cycle();
    alu(3, 1, 2); cycle();
    alu(9, 1, 1); cycle();
    alu(4, 3, 3); #1;
    chk("fwd_mem_rs1", fwd1_sel, 2); chk("fwd_mem_rs2", fwd2_sel, 2);
    cycle();
    alu(0, 1, 2); cycle();
    alu(4, 0, 0); #1;
    chk("fwd_x0", {fwd1_sel, fwd2_sel}, 0);
    cycle();

    // Load-use stall released by a same-cycle response
    lw(5, 1); cycle();
    alu(6, 5, 1); #1;
    chk("ldu_stall", stall, 1); chk("ldu_flush", flush_ex, 1); chk("ldu_issue", issue, 0);
    cycle();
    mem_resp_valid = 1; mem_resp_rd = 5; #1;
    chk("ldu_bypass_issue", issue, 1); chk("ldu_bypass_stall", stall, 0);
    cycle();
    mem_resp_valid = 0;

    // jalr resolved on the third wait cycle
    jalr(1, 2); cycle();
    alu(8, 3, 4);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      jalr_done = (i == 2); #1;
      if (stall) cnt++;
      cycle();
    end
    jalr_done = 0; #1;
    if (stall) cnt++;
    chk("jalr_stall_cycles", cnt, 3);
    chk("jalr_resume_issue", issue, 1);
    cycle();

    // Load limit: third back-to-back load held until a response frees a slot
    lw(10, 1); cycle();
    lw(11, 1); cycle();
    lw(12, 1); #1;
    chk("full_stall", stall, 1);
    cycle(); cycle();
    mem_resp_valid = 1; mem_resp_rd = 10; #1;
    chk("full_resp_still_held", stall, 1);
    cycle();
    mem_resp_valid = 0; #1;
    chk("full_then_issue", issue, 1);
    cycle();
    nop();
    mem_resp_valid = 1; mem_resp_rd = 11; cycle();
    mem_resp_rd = 12; cycle();
    mem_resp_valid = 0; #1;
    chk("drained", ld_pending, 0);

    // Store held by memory for two cycles, issued once
    sw(1, 2); mem_req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1; chk("sw_wait_stall", stall, 1);
      cycle();
    end
    mem_req_ready = 1; #1;
    chk("sw_issue", issue, 1);
    cycle();
    nop(); #1;
    chk("sw_no_double", issue, 0);
    cycle();

    // jalr never resolved: timeout, then reset mid-wait
    lw(7, 1); cycle();
    jalr(1, 2); cycle();
    alu(8, 1, 2);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) chk("tmo_not_yet", err_tmo, 0);
      cycle();
    end
    chk("tmo_sticky", err_tmo, 1);
    rst = 1'b0; #1;
    chk_idle("midwait_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    cycle();

    // Randomized traffic; decode holds its instruction while stalled
    held = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        kind = $urandom_range(0, 9);
        if (kind <= 3)      alu(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else if (kind <= 5) lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else if (kind == 6) sw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else if (kind == 7) jalr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        else                nop();
      end
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = ($urandom_range(0, 3) == 0);
      mem_resp_rd    = 5'($urandom_range(0, 7));
      jalr_done      = ($urandom_range(0, 2) == 0);
      cycle();
      held = e_stall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
